// File: rtl/if_fetch_unit_if.sv
// Bundles the fetch unit's decode-side handshake, branch bus and instruction-SRAM
// request/response signals. The master modport is the fetch unit.
interface if_fetch_unit_if;
    logic        ID_Allow_in;
    logic [33:0] br_bus;
    logic        IF_to_ID_Valid;
    logic [63:0] IF_to_ID_Bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  ID_Allow_in, br_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output IF_to_ID_Valid, IF_to_ID_Bus, inst_sram_req, inst_sram_addr
    );

    modport slave (
        output ID_Allow_in, br_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  IF_to_ID_Valid, IF_to_ID_Bus, inst_sram_req, inst_sram_addr
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: single-outstanding SRAM reads, one-entry buffer to decode,
// branch redirect with wrong-path squash. Define IF_PERF_CNT_EN for fetch/squash counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic              clk,
    input  logic              reset,
    if_fetch_unit_if.master   fetch_io
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       if_fetch_cnt,
    output logic [31:0]       if_squash_cnt
`endif
);

    typedef enum logic [1:0] {SReq, SWait, SHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] tgt_q, tgt_d;
    logic        fs_valid_q, fs_valid_d;
    logic        redir_q, redir_d;
    logic        transfer, squash;

    logic        br_taken;
    logic [31:0] br_target;
    logic        unused_stall;

    assign br_taken     = fetch_io.br_bus[33];
    assign br_target    = fetch_io.br_bus[32:1];
    assign unused_stall = fetch_io.br_bus[0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        tgt_d      = tgt_q;
        fs_valid_d = fs_valid_q;
        redir_d    = redir_q;
        transfer   = 1'b0;
        squash     = 1'b0;

        unique case (state_q)
            SReq: begin
                // The request address stays put; a branch only marks the reply as wrong-path.
                if (br_taken) begin
                    redir_d = 1'b1;
                    tgt_d   = br_target;
                end
                if (fetch_io.inst_sram_addr_ok) begin
                    state_d = SWait;
                end
            end
            SWait: begin
                if (fetch_io.inst_sram_data_ok) begin
                    if (br_taken) begin
                        pc_d    = br_target;
                        redir_d = 1'b0;
                        state_d = SReq;
                        squash  = 1'b1;
                    end else if (redir_q) begin
                        pc_d    = tgt_q;
                        redir_d = 1'b0;
                        state_d = SReq;
                        squash  = 1'b1;
                    end else begin
                        buf_pc_d   = pc_q;
                        buf_inst_d = fetch_io.inst_sram_rdata;
                        fs_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = SHold;
                    end
                end else if (br_taken) begin
                    redir_d = 1'b1;
                    tgt_d   = br_target;
                end
            end
            SHold: begin
                // A branch wins over a simultaneous transfer: the held word is wrong-path.
                if (br_taken) begin
                    fs_valid_d = 1'b0;
                    pc_d       = br_target;
                    state_d    = SReq;
                    squash     = 1'b1;
                end else if (fs_valid_q && fetch_io.ID_Allow_in) begin
                    fs_valid_d = 1'b0;
                    state_d    = SReq;
                    transfer   = 1'b1;
                end
            end
            default: state_d = SReq;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SReq;
            pc_q       <= RESET_PC;
            buf_pc_q   <= 32'd0;
            buf_inst_q <= 32'd0;
            tgt_q      <= 32'd0;
            fs_valid_q <= 1'b0;
            redir_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            tgt_q      <= tgt_d;
            fs_valid_q <= fs_valid_d;
            redir_q    <= redir_d;
        end
    end

    assign fetch_io.inst_sram_req  = (state_q == SReq) & ~reset;
    assign fetch_io.inst_sram_addr = pc_q;
    assign fetch_io.IF_to_ID_Valid = fs_valid_q;
    assign fetch_io.IF_to_ID_Bus   = {buf_pc_q, buf_inst_q};

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, squash_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q  <= 32'd0;
            squash_cnt_q <= 32'd0;
        end else begin
            if (transfer) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (squash)   squash_cnt_q <= squash_cnt_q + 32'd1;
        end
    end

    assign if_fetch_cnt  = fetch_cnt_q;
    assign if_squash_cnt = squash_cnt_q;
`else
    logic unused_cnt_evt;
    assign unused_cnt_evt = transfer ^ squash;
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Generates fetch PCs and issues single-outstanding reads on a request/response instruction-SRAM interface.
- Buffers the returned word and hands {pc, inst} to decode with a valid/allow-in handshake.
- Consumes decode's branch bus to redirect fetch and squash wrong-path instructions, including in-flight responses.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ID_Allow_in  in  1  decode can accept an instruction this cycle.
- br_bus  in  34  {br_taken[33], br_target[32:1], stall[0]}; stall is unused here.
- IF_to_ID_Valid  out  1  IF_to_ID_Bus holds a valid instruction.
- IF_to_ID_Bus  out  64  {pc[63:32], inst[31:0]}.
- inst_sram_req  out  1  read request.
- inst_sram_addr  out  32  word address of the request.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  read data valid this cycle.
- inst_sram_rdata  in  32  read data.

Behaviour:
- Registers:
  - state ∈ {S_REQ, S_WAIT, S_HOLD}
  - pc_q: address of the current or next request
  - buf_pc, buf_inst
  - fs_valid
  - redir (1 bit), tgt_q (32 bits)
- Reset (asynchronous): state=S_REQ, pc_q=RESET_PC, fs_valid=0, redir=0, tgt_q=0, buf_pc=0, buf_inst=0.
- Outputs during reset: IF_to_ID_Valid=0, IF_to_ID_Bus=0, inst_sram_req=0, inst_sram_addr=RESET_PC.
- Combinational outputs:
  - inst_sram_req = (state==S_REQ) & ~reset
  - inst_sram_addr = pc_q
  - IF_to_ID_Valid = fs_valid
  - IF_to_ID_Bus = {buf_pc, buf_inst}
- S_REQ:
  - req=1.
  - addr is held stable until addr_ok; a branch never changes the address of an unaccepted request.
  - On addr_ok → S_WAIT.
- S_WAIT:
  - req=0. Stay until data_ok.
  - On data_ok with redir=0 and no br_taken:
    - buf_pc=pc_q, buf_inst=rdata, fs_valid=1
    - pc_q=pc_q+4 (mod 2^32)
    - → S_HOLD
  - On data_ok with redir=1: discard data, pc_q=tgt_q, redir=0 → S_REQ.
  - On data_ok with br_taken in the same cycle: discard data, pc_q=br_target, redir=0 → S_REQ.
- S_HOLD:
  - Transfer occurs when fs_valid & ID_Allow_in; then fs_valid=0 → S_REQ (next cycle req=1).
  - Without ID_Allow_in, the buffer is held unchanged indefinitely.
- Branch handling, br_taken=1 in a cycle:
  - S_REQ (whether or not addr_ok that cycle): redir=1, tgt_q=br_target; the request proceeds and its data is dropped.
  - S_WAIT without data_ok: redir=1, tgt_q=br_target.
  - S_HOLD: fs_valid=0, pc_q=br_target → S_REQ. The buffered word is wrong-path and is not re-offered, even if ID_Allow_in was high.
  - A later br_taken while redir=1 overwrites tgt_q (latest wins).
- Throughput: at most one instruction per 3 cycles when the SRAM returns addr_ok and data_ok with zero wait; there is exactly one outstanding request.
- Mid-operation reset: state is cleared immediately. The memory side is reset by the same signal, so no stale data_ok follows reset.
- A data_ok outside S_WAIT is a protocol error and is ignored.
- Misaligned targets are issued as-is; no exception path exists.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, the block adds two outputs, both reset to 0 and wrapping mod 2^32:
  - if_fetch_cnt [31:0]: increments on each decode transfer.
  - if_squash_cnt [31:0]: increments on each discarded response or squashed buffered word.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, SRAM zero-wait, ID_Allow_in=1 → req addr 1c000000, then 1c000004, 1c000008. Valid pulses carry {1c000000, rdata0}, etc., spaced 3 cycles apart.
- ID_Allow_in=0 for 5 cycles while in S_HOLD → IF_to_ID_Bus stable, no new req. Allow_in=1 → one transfer, then req to pc+4.
- br_taken target 1c000100 in S_HOLD → valid drops next cycle, buffered word never transferred, next req addr 1c000100.
- br_taken target 1c000200 in S_WAIT, data_ok 4 cycles later → data discarded, no valid. Next req addr 1c000200.
- br_taken coinciding with addr_ok in S_REQ, then a second br_taken target 1c000300 before data_ok → first response dropped, next req 1c000300.
- reset asserted mid-S_WAIT → outputs immediately 0 / req=0. After release, req addr 1c000000.
